// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration controller.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WR,
    RD,
    IGNORE
  } state_t;

  // Command opcodes live in bits [7:6] of the first byte of a frame.
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  localparam logic [7:0] DEFAULT_DEVICE_ID = 8'hA5;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with a one-cycle pulse on its synchronized rising edge.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// Sequences SPI slave bytes (command, address, data...) into config memory accesses.
// Define SPI_CFG_READ_EN to build in the READ command and the read-back path.
module spi_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVICE_ID   = DEFAULT_DEVICE_ID
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              ss,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  state_t state, state_next;

  logic byte_evt;
  logic ss_level;
  logic ss_lo;
  logic unused_rx_level;
  logic unused_ss_rise;

  logic [SYNC_STAGES-1:0] settle;
  logic                   ss_armed;

  logic cmd_start;
  logic bad_cmd;
  logic addr_load;
  logic wr_evt;
  logic addr_step;

`ifdef SPI_CFG_READ_EN
  logic is_read;
  logic is_read_next;
  logic rd_evt;
  logic rd_ret;
`else
  logic [7:0] unused_mem_rdata;
  assign unused_mem_rdata = mem_rdata;
  assign mem_re           = 1'b0;
`endif

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rx_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (rx_valid),
    .level    (unused_rx_level),
    .rise     (byte_evt)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (ss),
    .level    (ss_level),
    .rise     (unused_ss_rise)
  );

  assign ss_lo = ~ss_level;
  assign busy  = (state != IDLE);

`ifdef SPI_CFG_READ_EN
  assign addr_step = mem_we | rd_ret;
`else
  assign addr_step = mem_we;
`endif

  always_comb begin
    state_next = state;
    cmd_start  = 1'b0;
    bad_cmd    = 1'b0;
    addr_load  = 1'b0;
    wr_evt     = 1'b0;
`ifdef SPI_CFG_READ_EN
    is_read_next = is_read;
    rd_evt       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ss_lo && ss_armed) begin
          state_next = CMD;
          cmd_start  = 1'b1;
        end
      end
      CMD: begin
        if (byte_evt) begin
          if (rx_data[7:6] == CMD_WRITE) begin
            state_next = ADDR;
`ifdef SPI_CFG_READ_EN
            is_read_next = 1'b0;
          end else if (rx_data[7:6] == CMD_READ) begin
            state_next   = ADDR;
            is_read_next = 1'b1;
`endif
          end else begin
            state_next = IGNORE;
            bad_cmd    = 1'b1;
          end
        end
      end
      ADDR: begin
        if (byte_evt) begin
          addr_load  = 1'b1;
          state_next = WR;
`ifdef SPI_CFG_READ_EN
          if (is_read) begin
            rd_evt     = 1'b1;
            state_next = RD;
          end
`endif
        end
      end
      WR: wr_evt = byte_evt;
`ifdef SPI_CFG_READ_EN
      RD: rd_evt = byte_evt;
`endif
      default: ;
    endcase
    // Losing ss wins over everything, but a byte seen in the same cycle is still acted on.
    if (state != IDLE && !ss_lo) begin
      state_next = IDLE;
    end
  end

  // A new frame may start only after ss has been seen high, so a reset mid-frame
  // leaves the rest of that frame ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      settle    <= '0;
      ss_armed  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      cmd_err   <= 1'b0;
      tx_data   <= 8'h00;
`ifdef SPI_CFG_READ_EN
      is_read   <= 1'b0;
      mem_re    <= 1'b0;
      rd_ret    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
      if (cmd_start) begin
        ss_armed <= 1'b0;
      end else if (settle[SYNC_STAGES-1] && !ss_lo) begin
        ss_armed <= 1'b1;
      end

      if (cmd_start) begin
        cmd_err <= 1'b0;
      end else if (bad_cmd) begin
        cmd_err <= 1'b1;
      end

      mem_we <= wr_evt;
      if (wr_evt) begin
        mem_wdata <= rx_data;
      end

      if (addr_load) begin
        mem_addr <= rx_data[ADDR_W-1:0];
      end else if (addr_step) begin
        mem_addr <= mem_addr + 1'b1;
      end

`ifdef SPI_CFG_READ_EN
      is_read <= is_read_next;
      mem_re  <= rd_evt;
      rd_ret  <= mem_re;
      if (cmd_start || (state != IDLE && state_next == IDLE)) begin
        tx_data <= DEVICE_ID;
      end else if (rd_ret && state == RD) begin
        tx_data <= mem_rdata;
      end
`else
      tx_data <= DEVICE_ID;
`endif
    end
  end

endmodule

// File: doc/spi_cfg_ctrl.md
Name: spi_cfg_ctrl

Overview:
- System-clock-domain controller that sequences the SPI slave byte stream into register/memory accesses.
- Used for loading SNN weights/delays and reading them back.
- Synchronizes the slave's byte-valid flag and SS, decodes a command/address/data protocol, and drives a single-port config memory interface.
- Supplies the next byte to send back to the master.

Parameters:
ADDR_W, 7, config memory address width (1..8)
SYNC_STAGES, 2, synchronizer depth for rx_valid and SS (>=2)
DEVICE_ID, 8'hA5, byte returned to master during command/address bytes

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
rx_data  in  8  received byte from SPI slave (stable >=7 SCLK periods after rx_valid)
rx_valid  in  1  SPI slave data-valid, asynchronous to CLK, high ~1 SCLK period per byte
ss  in  1  SPI slave select, active low, asynchronous to CLK
tx_data  out  8  byte to SPI slave data_to_send
mem_addr  out  ADDR_W  config memory address
mem_wdata  out  8  config memory write data
mem_we  out  1  write strobe, 1 CLK pulse
mem_re  out  1  read strobe, 1 CLK pulse
mem_rdata  in  8  read data, valid 1 CLK after mem_re
busy  out  1  transaction in progress (state != IDLE)
cmd_err  out  1  sticky illegal-command flag, cleared at next transaction start

Behaviour:
- Interface: one clock (CLK); RESET is synchronous and active-high, sampled only on CLK rising edge.
- Reset values: tx_data=8'h00, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, cmd_err=0, state=IDLE, synchronizers cleared (ss sync to 1).
- RESET mid-transaction: abort on the next CLK edge; no strobe issued in that cycle; remaining bytes of the frame are ignored until ss is seen high then low again.
- Clocking constraint: f_CLK >= 4 x f_SCLK.
- Byte event: 1-CLK pulse on the synchronized rising edge of rx_valid; rx_data is captured in that cycle.
- ss_lo: synchronized ss low.
- Protocol: byte0 = command, byte1 = address, byte2.. = data, with address auto-increment.
- Commands: 8'h80 | x = WRITE, 8'hC0 | x = READ (low 6 bits ignored). Any other value sets cmd_err and goes to IGNORE.
- States:
  - IDLE: on ss_lo -> CMD; clear cmd_err; tx_data<=DEVICE_ID.
  - CMD: byte event -> ADDR (remember R/W), or IGNORE on bad command.
  - ADDR: byte event: mem_addr<=rx_data[ADDR_W-1:0].
    - WRITE -> WR.
    - READ -> pulse mem_re; next cycle tx_data<=mem_rdata, mem_addr++; -> RD.
  - WR: each byte event: mem_wdata<=rx_data and mem_we pulse in the same cycle at the current mem_addr; the following cycle mem_addr++.
  - RD: each byte event (dummy data ignored): mem_re pulse at mem_addr; next cycle tx_data<=mem_rdata, mem_addr++.
  - IGNORE: discard all bytes.
- Address wraps modulo 2^ADDR_W (e.g. 7'h7F -> 7'h00), with no error.
- ss deasserted (synced high) in any non-IDLE state -> IDLE next cycle; tx_data<=DEVICE_ID.
- Simultaneous byte event and ss-high in the same cycle: the byte is fully processed (write/read issued), then -> IDLE.
- A byte event while in IDLE is ignored.
- tx_data changes only in the cycle after a byte event, a read return, or a state entry, so it is stable well before the next byte's first SCLK falling edge.
- mem_we and mem_re are never high in the same cycle.

Optional Feature:
Macro SPI_CFG_READ_EN.
- Defined: READ command supported as above.
- Undefined: READ is treated as an illegal command (cmd_err=1, -> IGNORE); mem_re tied 0; RD state and mem_rdata path removed; tx_data is always DEVICE_ID after reset deasserts.

Decomposition:
- Package spi_cfg_pkg:
  - state enum (IDLE, CMD, ADDR, WR, RD, IGNORE)
  - command constants CMD_WRITE=2'b10, CMD_READ=2'b11 (on bits [7:6])
  - default DEVICE_ID
- One sub-module spi_sync_edge: SYNC_STAGES flop synchronizer with rising-edge pulse output, instanced for rx_valid and for ss.

Test Plan:
- Write burst: ss low, bytes 80,05,11,22,33, ss high -> mem_we pulses with (05,11),(06,22),(07,33); busy falls after ss high; cmd_err=0.
- Read (SPI_CFG_READ_EN): memory[10]=3C, [11]=4D; bytes C0,10,00,00 -> tx_data=A5 for bytes 0-1, then 3C before byte 2, 4D before byte 3.
- Wrap: write cmd, address 7F, data AA,BB -> writes at 7F then 00.
- Illegal command 40 then 01,02 -> cmd_err=1, no mem_we/mem_re; next frame's start clears cmd_err.
- RESET asserted after address byte of a write frame, released, then 2 more bytes in the same frame -> no mem_we, all outputs at reset values.
- Byte event coincident with ss rising -> write still issued, state IDLE the next cycle.
